// File: rtl/mem_access_ctrl_pkg.sv
// Shared op/state encodings and lane helpers for the MEM-stage data-memory sequencer.
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        OpLb  = 3'd0,
        OpLbu = 3'd1,
        OpLh  = 3'd2,
        OpLhu = 3'd3,
        OpLw  = 3'd4,
        OpSb  = 3'd5,
        OpSh  = 3'd6,
        OpSw  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StErr  = 2'd2,
        StDone = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord
    } size_e;

    function automatic size_e op_size(op_e op);
        case (op)
            OpLb, OpLbu, OpSb: return SzByte;
            OpLh, OpLhu, OpSh: return SzHalf;
            default:           return SzWord;
        endcase
    endfunction

    function automatic logic is_store(op_e op);
        return op inside {OpSb, OpSh, OpSw};
    endfunction

    function automatic logic misaligned(op_e op, logic [1:0] a);
        case (op_size(op))
            SzHalf:  return a[0];
            SzWord:  return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Little-endian lanes: bit i enables bits 8i+7:8i.
    function automatic logic [3:0] byte_en(op_e op, logic [1:0] a);
        case (op_size(op))
            SzByte:  return 4'(4'b0001 << a);
            SzHalf:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(op_e op, logic [31:0] wd);
        case (op)
            OpSb:    return {4{wd[7:0]}};
            OpSh:    return {2{wd[15:0]}};
            OpSw:    return wd;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/load_align_extend.sv
// Combinational load lane select and sign/zero extension of returned memory data.
module load_align_extend
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (op_e'(op_i))
            OpLb:    result_o = {{24{byte_sel[7]}}, byte_sel};
            OpLbu:   result_o = {24'h0, byte_sel};
            OpLh:    result_o = {{16{half_sel[15]}}, half_sel};
            OpLhu:   result_o = {16'h0, half_sel};
            OpLw:    result_o = rdata_i;
            default: result_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: alignment check, req/ack data-memory handshake with timeout,
// store lane replication and load extension; stalls the pipeline until completion.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TimeoutCyc = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] read_data_o,
    output logic        align_err_o,
    output logic        bus_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_byte_en_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [7:0] CntLast = 8'(TimeoutCyc - 1);

    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        align_err_q, align_err_d;
    logic        bus_err_q, bus_err_d;
    logic [31:0] load_result;
    op_e         op_in;

    assign op_in = op_e'(op_i);

    load_align_extend u_load_align_extend (
        .op_i      (op_q),
        .addr_lo_i (addr_q[1:0]),
        .rdata_i   (mem_rdata_i),
        .result_o  (load_result)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            op_q        <= OpLb;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            cnt_q       <= 8'h0;
            rdata_q     <= 32'h0;
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            align_err_q <= align_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        align_err_d = align_err_q;
        bus_err_d   = bus_err_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    rdata_d     = 32'h0;
                    bus_err_d   = 1'b0;
                    cnt_d       = 8'h0;
                    if (misaligned(op_in, addr_i[1:0])) begin
                        align_err_d = 1'b1;
                        state_d     = StErr;
                    end else begin
                        align_err_d = 1'b0;
                        op_d        = op_in;
                        addr_d      = addr_i;
                        wdata_d     = store_data(op_in, wdata_i);
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                // An ack on the final allowed cycle still wins over the timeout.
                if (mem_ack_i) begin
                    rdata_d = is_store(op_q) ? 32'h0 : load_result;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    bus_err_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StErr:   state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        stall_o       = (state_q == StIdle && start_i) || state_q == StReq || state_q == StErr;
        done_o        = state_q == StDone;
        align_err_o   = done_o && align_err_q;
        bus_err_o     = done_o && bus_err_q;
        read_data_o   = rdata_q;
        mem_req_o     = state_q == StReq;
        mem_we_o      = mem_req_o && is_store(op_q);
        mem_addr_o    = mem_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
        mem_byte_en_o = mem_req_o ? byte_en(op_q, addr_q[1:0]) : 4'h0;
        mem_wdata_o   = mem_req_o ? wdata_q : 32'h0;
    end

endmodule
